// File: rtl/biriscv_divider_pkg.sv
// Shared RV32M decode constants and divider state encoding.
package biriscv_divider_pkg;

    localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;
    localparam logic [6:0] RV32M_OPCODE = 7'b0110011;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] neg_if(input logic [31:0] value, input logic do_neg);
        return do_neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/biriscv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module biriscv_div_step
    import biriscv_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dvd_o,
    output logic            qbit_o
);

    // The partial remainder can briefly exceed XLEN bits after the shift.
    logic [XLEN:0] shifted;

    assign shifted = {rem_i, dvd_i[XLEN-1]};
    assign qbit_o  = (shifted >= {1'b0, divisor_i});
    assign rem_o   = qbit_o ? (shifted[XLEN-1:0] - divisor_i) : shifted[XLEN-1:0];
    assign dvd_o   = {dvd_i[XLEN-2:0], 1'b0};

endmodule

// File: rtl/biriscv_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with busy/writeback handshake.
module biriscv_divider
    import biriscv_divider_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            writeback_valid_o,
    output logic [XLEN-1:0] writeback_value_o
);

    div_state_e      state_q;
    logic            busy_q;
    logic            wb_valid_q;
    logic [XLEN-1:0] wb_value_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] special_val_q;
    logic [5:0]      cnt_q;
    logic            want_rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            special_q;

    logic [2:0]      funct3;
    logic            is_div_op;
    logic            accept;
    logic            is_signed;
    logic            want_rem;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] wb_value_d;
    logic            unused_opcode_bits;

    logic [XLEN-1:0] step_rem_in;
    logic [XLEN-1:0] step_dvd_in;
    logic [XLEN-1:0] step_div_in;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_dvd;
    logic            step_qbit;

    assign funct3    = opcode_opcode_i[14:12];
    assign is_div_op = (opcode_opcode_i[6:0] == RV32M_OPCODE) &&
                       (opcode_opcode_i[31:25] == RV32M_FUNCT7) && funct3[2];
    assign accept    = opcode_valid_i && is_div_op && !flush_i && !busy_q && (state_q == ST_IDLE);
    assign unused_opcode_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7]};

    assign is_signed   = ~funct3[0];
    assign want_rem    = funct3[1];
    assign abs_a       = neg_if(opcode_ra_operand_i, is_signed & opcode_ra_operand_i[XLEN-1]);
    assign abs_b       = neg_if(opcode_rb_operand_i, is_signed & opcode_rb_operand_i[XLEN-1]);
    assign div_by_zero = (opcode_rb_operand_i == '0);
    assign overflow    = is_signed && (opcode_ra_operand_i == 32'h8000_0000) &&
                         (opcode_rb_operand_i == 32'hFFFF_FFFF);
    assign special_val = div_by_zero ? (want_rem ? opcode_ra_operand_i : '1)
                                     : (want_rem ? '0 : 32'h8000_0000);

    // The first iteration runs on the accept edge straight from the operand ports.
    assign step_rem_in = (state_q == ST_IDLE) ? '0    : rem_q;
    assign step_dvd_in = (state_q == ST_IDLE) ? abs_a : dvd_q;
    assign step_div_in = (state_q == ST_IDLE) ? abs_b : divisor_q;

    biriscv_div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (step_rem_in),
        .dvd_i     (step_dvd_in),
        .divisor_i (step_div_in),
        .rem_o     (step_rem),
        .dvd_o     (step_dvd),
        .qbit_o    (step_qbit)
    );

    assign wb_value_d = special_q  ? special_val_q :
                        want_rem_q ? neg_if(rem_q, r_neg_q) : neg_if(dvd_q, q_neg_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_value_q    <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            divisor_q     <= '0;
            special_val_q <= '0;
            cnt_q         <= '0;
            want_rem_q    <= 1'b0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            special_q     <= 1'b0;
        end else if (flush_i) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wb_valid_q <= 1'b0;
                    busy_q     <= accept;
                    if (accept) begin
                        rem_q         <= step_rem;
                        dvd_q         <= step_dvd | {{(XLEN-1){1'b0}}, step_qbit};
                        divisor_q     <= abs_b;
                        special_val_q <= special_val;
                        special_q     <= div_by_zero | overflow;
                        want_rem_q    <= want_rem;
                        q_neg_q       <= is_signed & (opcode_ra_operand_i[XLEN-1] ^ opcode_rb_operand_i[XLEN-1]);
                        r_neg_q       <= is_signed & opcode_ra_operand_i[XLEN-1];
                        cnt_q         <= 6'd30;
                        state_q       <= ((FAST_SPECIAL != 0) && (div_by_zero || overflow)) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    rem_q <= step_rem;
                    dvd_q <= step_dvd | {{(XLEN-1){1'b0}}, step_qbit};
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wb_valid_q <= 1'b1;
                    wb_value_q <= wb_value_d;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o            = busy_q;
    assign writeback_valid_o = wb_valid_q;
    assign writeback_value_o = wb_value_q;

endmodule

// File: tb/tb_biriscv_divider.sv
// Randomized and directed bench for biriscv_divider against an arithmetic reference model.
module tb_biriscv_divider;

    localparam logic [2:0] F_MUL  = 3'b000;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        flush;
    logic [31:0] opc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        busy_f, wbv_f, busy_s, wbv_s;
    logic [31:0] wbval_f, wbval_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    biriscv_divider #(.XLEN(32), .FAST_SPECIAL(1)) dut (
        .clk_i(clk), .rst_i(rst_n), .opcode_valid_i(valid), .opcode_opcode_i(opc),
        .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb), .flush_i(flush),
        .busy_o(busy_f), .writeback_valid_o(wbv_f), .writeback_value_o(wbval_f)
    );

    biriscv_divider #(.XLEN(32), .FAST_SPECIAL(0)) dut_slow (
        .clk_i(clk), .rst_i(rst_n), .opcode_valid_i(valid), .opcode_opcode_i(opc),
        .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb), .flush_i(flush),
        .busy_o(busy_s), .writeback_valid_o(wbv_s), .writeback_value_o(wbval_s)
    );

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
        case (f3[1:0])
            2'b00:   begin sr = sa / sb; return sr; end
            2'b01:   return a / b;
            2'b10:   begin sr = sa % sb; return sr; end
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] mk_op(input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[31:25] = 7'b0000001;
        r[14:12] = f3;
        r[6:0]   = 7'b0110011;
        return r;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid = 1'b1;
        opc   = mk_op(f3);
        ra    = a;
        rb    = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        ra    = $urandom;
        rb    = $urandom;
    endtask

    task automatic wait_wb(input bit slow, output int cyc, output logic [31:0] val,
                           output bit busy_ok, output bit seen);
        cyc = 0; seen = 1'b0; busy_ok = 1'b1; val = '0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((slow ? busy_s : busy_f) !== 1'b1) busy_ok = 1'b0;
            if ((slow ? wbv_s : wbv_f) === 1'b1) begin
                seen = 1'b1;
                val  = slow ? wbval_s : wbval_f;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; opc = '0; ra = '0; rb = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_f); end
        checks++; if (wbv_f !== 1'b0) begin errors++; $display("FAIL reset_wbv got %b want 0", wbv_f); end
        checks++; if (wbval_f !== 32'h0) begin errors++; $display("FAIL reset_value got %h want 0", wbval_f); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy_slow got %b want 0", busy_s); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_div();
        int cyc; logic [31:0] val; bit bok, seen;
        issue(F_DIV, 32'd20, 32'hFFFF_FFFD);
        checks++; if (busy_f !== 1'b1) begin errors++; $display("FAIL single_busy_after_accept got %b want 1", busy_f); end
        wait_wb(1'b0, cyc, val, bok, seen);
        checks++; if (!seen || val !== 32'hFFFF_FFFA) begin errors++; $display("FAIL single_value got %h want fffffffa (seen %b)", val, seen); end
        checks++; if (cyc !== 32) begin errors++; $display("FAIL single_latency got %0d want 32", cyc); end
        checks++; if (!bok) begin errors++; $display("FAIL single_busy_dropped got 0 want 1"); end
        @(posedge clk); #1;
        checks++; if (wbv_f !== 1'b0 || busy_f !== 1'b0) begin errors++; $display("FAIL single_release got wbv=%b busy=%b want 0 0", wbv_f, busy_f); end
        checks++; if (wbval_f !== 32'hFFFF_FFFA) begin errors++; $display("FAIL single_value_hold got %h want fffffffa", wbval_f); end
    endtask

    task automatic test_back_to_back();
        op_t ops[4];
        int cyc; logic [31:0] val, exp; bit bok, seen;
        ops[0] = '{F_REM,  32'hFFFF_FFEC, 32'd3};
        ops[1] = '{F_DIVU, 32'hFFFF_FFEC, 32'd3};
        ops[2] = '{F_REMU, 32'hFFFF_FFEC, 32'd3};
        ops[3] = '{F_DIV,  32'hFFFF_FFEC, 32'd3};
        foreach (ops[i]) begin
            exp = model(ops[i].f3, ops[i].a, ops[i].b);
            issue(ops[i].f3, ops[i].a, ops[i].b);
            wait_wb(1'b0, cyc, val, bok, seen);
            checks++; if (!seen || val !== exp) begin errors++; $display("FAIL b2b_value[%0d] got %h want %h", i, val, exp); end
            checks++; if (cyc !== 32 || !bok) begin errors++; $display("FAIL b2b_timing[%0d] got lat=%0d busy_ok=%b want 32 1", i, cyc, bok); end
            @(posedge clk); #1;
            checks++; if (busy_f !== 1'b0 || wbv_f !== 1'b0) begin errors++; $display("FAIL b2b_release[%0d] got busy=%b wbv=%b want 0 0", i, busy_f, wbv_f); end
        end
    endtask

    task automatic test_special_fast();
        op_t ops[6];
        int cyc; logic [31:0] val, exp; bit bok, seen;
        ops[0] = '{F_DIVU, 32'd7, 32'd0};
        ops[1] = '{F_REM,  32'd7, 32'd0};
        ops[2] = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF};
        ops[3] = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF};
        ops[4] = '{F_DIV,  32'hFFFF_FFF7, 32'd0};
        ops[5] = '{F_REMU, 32'h0000_DEAD, 32'd0};
        foreach (ops[i]) begin
            exp = model(ops[i].f3, ops[i].a, ops[i].b);
            issue(ops[i].f3, ops[i].a, ops[i].b);
            wait_wb(1'b0, cyc, val, bok, seen);
            checks++; if (!seen || val !== exp) begin errors++; $display("FAIL fast_value[%0d] got %h want %h", i, val, exp); end
            checks++; if (cyc !== 1 || !bok) begin errors++; $display("FAIL fast_timing[%0d] got lat=%0d busy_ok=%b want 1 1", i, cyc, bok); end
            @(posedge clk); #1;
            checks++; if (busy_f !== 1'b0 || wbv_f !== 1'b0) begin errors++; $display("FAIL fast_release[%0d] got busy=%b wbv=%b want 0 0", i, busy_f, wbv_f); end
        end
    endtask

    task automatic test_special_slow();
        op_t ops[4];
        int cyc, guard; logic [31:0] val, exp; bit bok, seen;
        ops[0] = '{F_DIVU, 32'd7, 32'd0};
        ops[1] = '{F_REM,  32'd7, 32'd0};
        ops[2] = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF};
        ops[3] = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF};
        guard = 0;
        while ((busy_s !== 1'b0 || busy_f !== 1'b0) && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL slow_idle_wait got busy=%b want 0", busy_s); end
        foreach (ops[i]) begin
            exp = model(ops[i].f3, ops[i].a, ops[i].b);
            issue(ops[i].f3, ops[i].a, ops[i].b);
            wait_wb(1'b1, cyc, val, bok, seen);
            checks++; if (!seen || val !== exp) begin errors++; $display("FAIL slow_value[%0d] got %h want %h", i, val, exp); end
            checks++; if (cyc !== 32 || !bok) begin errors++; $display("FAIL slow_timing[%0d] got lat=%0d busy_ok=%b want 32 1", i, cyc, bok); end
            @(posedge clk); #1;
            checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL slow_release[%0d] got busy=%b want 0", i, busy_s); end
        end
    endtask

    task automatic test_ignore_and_flush();
        int cyc; logic [31:0] val; bit bok, seen, saw_wb;
        issue(F_MUL, 32'd3, 32'd4);
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL mul_ignored got busy=%b want 0", busy_f); end
        issue(F_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        valid = 1'b1; opc = mk_op(F_DIVU); ra = 32'd9; rb = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        wait_wb(1'b0, cyc, val, bok, seen);
        checks++; if (!seen || val !== 32'd14) begin errors++; $display("FAIL busy_issue_value got %h want 0000000e", val); end
        checks++; if (cyc + 6 !== 32) begin errors++; $display("FAIL busy_issue_latency got %0d want 32", cyc + 6); end
        @(posedge clk); #1;
        checks++; if (busy_f !== 1'b0 || wbv_f !== 1'b0) begin errors++; $display("FAIL busy_issue_extra got busy=%b wbv=%b want 0 0", busy_f, wbv_f); end
        issue(F_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++; if (busy_f !== 1'b0 || wbv_f !== 1'b0) begin errors++; $display("FAIL flush_mid got busy=%b wbv=%b want 0 0", busy_f, wbv_f); end
        @(negedge clk);
        flush = 1'b1; valid = 1'b1; opc = mk_op(F_DIVU); ra = 32'd9; rb = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL flush_beats_valid got busy=%b want 0", busy_f); end
        issue(F_DIVU, 32'd50, 32'd5);
        repeat (31) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        saw_wb = 1'b0;
        repeat (40) begin
            if (wbv_f === 1'b1) saw_wb = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_wb || busy_f !== 1'b0) begin errors++; $display("FAIL flush_done got wb_seen=%b busy=%b want 0 0", saw_wb, busy_f); end
        checks++; if (wbval_f !== 32'd14) begin errors++; $display("FAIL flush_value_hold got %h want 0000000e", wbval_f); end
        issue(F_DIVU, 32'd9, 32'd3);
        wait_wb(1'b0, cyc, val, bok, seen);
        checks++; if (!seen || val !== 32'd3 || cyc !== 32) begin errors++; $display("FAIL post_flush got %h lat=%0d want 00000003 32", val, cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int cyc; logic [31:0] val; bit bok, seen;
        issue(F_DIV, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy_f !== 1'b0 || wbv_f !== 1'b0) begin errors++; $display("FAIL async_rst_ctrl got busy=%b wbv=%b want 0 0", busy_f, wbv_f); end
        checks++; if (wbval_f !== 32'h0) begin errors++; $display("FAIL async_rst_value got %h want 0", wbval_f); end
        @(negedge clk); rst_n = 1'b1;
        issue(F_DIV, 32'd10, 32'd2);
        wait_wb(1'b0, cyc, val, bok, seen);
        checks++; if (!seen || val !== 32'd5 || cyc !== 32) begin errors++; $display("FAIL post_reset got %h lat=%0d want 00000005 32", val, cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int cyc, want_lat; logic [31:0] val, exp, a, b; logic [2:0] f3; bit bok, seen;
        for (int n = 0; n < 40; n++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                4: a = 32'h0;
                default: ;
            endcase
            exp      = model(f3, a, b);
            want_lat = is_special(f3, a, b) ? 1 : 32;
            issue(f3, a, b);
            wait_wb(1'b0, cyc, val, bok, seen);
            checks++;
            if (!seen || val !== exp || cyc !== want_lat || !bok) begin
                errors++;
                $display("FAIL rand[%0d] f3=%b a=%h b=%h got %h lat=%0d busy_ok=%b want %h lat=%0d",
                         n, f3, a, b, val, cyc, bok, exp, want_lat);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_div();
        test_back_to_back();
        test_special_fast();
        test_special_slow();
        test_ignore_and_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
